// File: rtl/apb_bus_pkg.sv
// rtl/apb_bus_pkg.sv - shared types and constants for the CPU-to-APB bridge
package apb_bus_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [31:0] S1_BASE_DEFAULT = 32'h4000_D000;
    localparam logic [31:0] S1_MASK_DEFAULT = 32'hFFFF_F000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        NOSLV  = 2'd3
    } state_t;

endpackage

// File: rtl/apb_bus_if.sv
// rtl/apb_bus_if.sv - CPU-side simple bus plus APB slave-1 port, seen from the bridge
interface apb_bus_if #(
    parameter int ADDR_WIDTH = 32
);
    import apb_bus_pkg::*;

    logic                    HSEL;
    logic [ADDR_WIDTH-1:0]   HADDR;
    logic                    HWRITE;
    logic [3:0]              HBE;
    logic [DATA_WIDTH-1:0]   HWDATA;
    logic [DATA_WIDTH-1:0]   HRDATA;
    logic                    HREADY;
    logic                    HREADYOUT;

    logic                    PSEL1;
    logic                    PENABLE_S1;
    logic                    PREADY_S1;
    logic [ADDR_WIDTH-1:0]   PADDR_S1;
    logic                    PWRITE_S1;
    logic [3:0]              PBE_S1;
    logic [DATA_WIDTH-1:0]   PWDATA_S1;
    logic [DATA_WIDTH-1:0]   PRDATA_S1;

    // The bridge is the APB master; CPU and peripheral together form the other side.
    modport master (
        input  HSEL, HADDR, HWRITE, HBE, HWDATA, HREADY, PREADY_S1, PRDATA_S1,
        output HRDATA, HREADYOUT, PSEL1, PENABLE_S1, PADDR_S1, PWRITE_S1, PBE_S1, PWDATA_S1
    );

    modport slave (
        output HSEL, HADDR, HWRITE, HBE, HWDATA, HREADY, PREADY_S1, PRDATA_S1,
        input  HRDATA, HREADYOUT, PSEL1, PENABLE_S1, PADDR_S1, PWRITE_S1, PBE_S1, PWDATA_S1
    );

endinterface

// File: rtl/apb_bus.sv
// rtl/apb_bus.sv - single-slave bridge: captures one CPU transfer and runs APB SETUP/ACCESS
module apb_bus
    import apb_bus_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] S1_BASE    = S1_BASE_DEFAULT,
    parameter logic [ADDR_WIDTH-1:0] S1_MASK    = S1_MASK_DEFAULT
) (
    input  logic      PCLK,
    input  logic      PRESETn,
    apb_bus_if.master bus
);

    state_t state;
    state_t state_next;
    logic   accept;
    logic   s1_hit;

    assign s1_hit = (bus.HADDR & S1_MASK) == S1_BASE;

    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // APB strobes and HREADYOUT are pure state decodes, so a reset edge clears them at once.
    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        bus.PSEL1      = 1'b0;
        bus.PENABLE_S1 = 1'b0;
        bus.HREADYOUT  = 1'b0;
        case (state)
            IDLE: begin
                bus.HREADYOUT = 1'b1;
                if (bus.HSEL && bus.HREADY) begin
                    accept     = 1'b1;
                    state_next = s1_hit ? SETUP : NOSLV;
                end
            end
            SETUP: begin
                bus.PSEL1  = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                bus.PSEL1      = 1'b1;
                bus.PENABLE_S1 = 1'b1;
                if (bus.PREADY_S1) begin
                    state_next = IDLE;
                end
            end
            NOSLV: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request fields stay latched after completion until the next acceptance.
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            bus.PADDR_S1  <= '0;
            bus.PWRITE_S1 <= 1'b0;
            bus.PBE_S1    <= '0;
            bus.PWDATA_S1 <= '0;
            bus.HRDATA    <= '0;
        end else begin
            if (accept) begin
                bus.PADDR_S1  <= bus.HADDR;
                bus.PWRITE_S1 <= bus.HWRITE;
                bus.PBE_S1    <= bus.HBE;
                bus.PWDATA_S1 <= bus.HWDATA;
            end
            if (state == ACCESS && bus.PREADY_S1 && !bus.PWRITE_S1) begin
                bus.HRDATA <= bus.PRDATA_S1;
            end
            if (state == NOSLV && !bus.PWRITE_S1) begin
                bus.HRDATA <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_bus.sv
// tb/tb_apb_bus.sv - scenario tasks plus an APB-completion scoreboard for apb_bus
module tb_apb_bus;

    logic PCLK;
    logic PRESETn;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        logic [3:0]  be;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    apb_bus_if #(.ADDR_WIDTH(32)) bus ();

    apb_bus #(.ADDR_WIDTH(32)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic push_exp(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] rd, input logic [3:0] be);
        exp_t e;
        e.w = w; e.addr = a; e.data = d; e.rdata = rd; e.be = be;
        sb.push_back(e);
    endtask

    task automatic drive_req(input logic w, input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] d);
        bus.HSEL = 1'b1; bus.HREADY = 1'b1; bus.HWRITE = w;
        bus.HADDR = a; bus.HBE = be; bus.HWDATA = d;
    endtask

    // Scoreboard: each APB completion pops the oldest expected transfer.
    always @(negedge PCLK) begin
        if (!PRESETn && bus.PSEL1 && bus.PENABLE_S1 && bus.PREADY_S1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got addr %h exp none", bus.PADDR_S1);
            end else begin
                mon_e = sb.pop_front();
                if ({bus.PADDR_S1, bus.PWRITE_S1, bus.PBE_S1} !== {mon_e.addr, mon_e.w, mon_e.be}) begin
                    errors++;
                    $display("FAIL sb_ctrl got %h/%b/%h exp %h/%b/%h", bus.PADDR_S1, bus.PWRITE_S1,
                             bus.PBE_S1, mon_e.addr, mon_e.w, mon_e.be);
                end
                if (mon_e.w) begin
                    checks++;
                    if (bus.PWDATA_S1 !== mon_e.data) begin
                        errors++;
                        $display("FAIL sb_pwdata got %h exp %h", bus.PWDATA_S1, mon_e.data);
                    end
                end else begin
                    @(posedge PCLK);
                    #1;
                    checks++;
                    if (bus.HRDATA !== mon_e.rdata) begin
                        errors++;
                        $display("FAIL sb_hrdata got %h exp %h", bus.HRDATA, mon_e.rdata);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        PRESETn = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.PSEL1, bus.PENABLE_S1, bus.PWRITE_S1, bus.HREADYOUT} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0001",
                     {bus.PSEL1, bus.PENABLE_S1, bus.PWRITE_S1, bus.HREADYOUT});
        end
        checks++;
        if ({bus.PADDR_S1, bus.PBE_S1, bus.PWDATA_S1, bus.HRDATA} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h exp 0", bus.PADDR_S1, bus.PBE_S1,
                     bus.PWDATA_S1, bus.HRDATA);
        end
        PRESETn = 1'b0;
        tick();
    endtask

    task automatic test_hready_qual();
        drive_req(1'b1, 32'h4000_D000, 4'hF, 32'h1111_1111);
        bus.HREADY = 1'b0;
        tick();
        bus.HSEL = 1'b0;
        checks++;
        if ({bus.PSEL1, bus.HREADYOUT} !== 2'b01 || bus.PADDR_S1 !== 32'h0) begin
            errors++;
            $display("FAIL hready_qual got psel %b rdy %b addr %h exp 0 1 0",
                     bus.PSEL1, bus.HREADYOUT, bus.PADDR_S1);
        end
        bus.HREADY = 1'b1;
    endtask

    task automatic test_write_hit();
        bus.PREADY_S1 = 1'b1;
        drive_req(1'b1, 32'h4000_D004, 4'hF, 32'hA5A5_A5A5);
        push_exp(1'b1, 32'h4000_D004, 32'hA5A5_A5A5, 32'h0, 4'hF);
        tick();
        bus.HSEL = 1'b0;
        checks++;
        if ({bus.PSEL1, bus.PENABLE_S1, bus.HREADYOUT} !== 3'b100) begin
            errors++;
            $display("FAIL wr_setup_ctrl got %b exp 100", {bus.PSEL1, bus.PENABLE_S1, bus.HREADYOUT});
        end
        checks++;
        if ({bus.PADDR_S1, bus.PWDATA_S1, bus.PWRITE_S1, bus.PBE_S1} !==
            {32'h4000_D004, 32'hA5A5_A5A5, 1'b1, 4'hF}) begin
            errors++;
            $display("FAIL wr_setup_fields got %h %h %b %h exp 4000d004 a5a5a5a5 1 f",
                     bus.PADDR_S1, bus.PWDATA_S1, bus.PWRITE_S1, bus.PBE_S1);
        end
        tick();
        checks++;
        if ({bus.PSEL1, bus.PENABLE_S1, bus.HREADYOUT} !== 3'b110) begin
            errors++;
            $display("FAIL wr_access got %b exp 110", {bus.PSEL1, bus.PENABLE_S1, bus.HREADYOUT});
        end
        tick();
        checks++;
        if ({bus.PSEL1, bus.PENABLE_S1, bus.HREADYOUT} !== 3'b001) begin
            errors++;
            $display("FAIL wr_done got %b exp 001", {bus.PSEL1, bus.PENABLE_S1, bus.HREADYOUT});
        end
    endtask

    task automatic test_read_wait();
        int acc = 0;
        bus.PREADY_S1 = 1'b0;
        bus.PRDATA_S1 = 32'h1234_5678;
        drive_req(1'b0, 32'h4000_D008, 4'h3, 32'hDEAD_0000);
        push_exp(1'b0, 32'h4000_D008, 32'h0, 32'h1234_5678, 4'h3);
        tick();
        bus.HSEL = 1'b0;
        tick();
        for (int i = 0; i < 20 && bus.PENABLE_S1; i++) begin
            acc++;
            checks++;
            if ({bus.PSEL1, bus.HREADYOUT, bus.PADDR_S1, bus.PWRITE_S1, bus.PBE_S1} !==
                {1'b1, 1'b0, 32'h4000_D008, 1'b0, 4'h3}) begin
                errors++;
                $display("FAIL rd_wait_stable cycle %0d got %b %b %h %b %h", acc,
                         bus.PSEL1, bus.HREADYOUT, bus.PADDR_S1, bus.PWRITE_S1, bus.PBE_S1);
            end
            bus.PREADY_S1 = (acc >= 3);
            tick();
        end
        checks++;
        if (acc !== 3) begin
            errors++;
            $display("FAIL rd_access_len got %0d exp 3", acc);
        end
        checks++;
        if (bus.HRDATA !== 32'h1234_5678 || bus.HREADYOUT !== 1'b1) begin
            errors++;
            $display("FAIL rd_result got %h rdy %b exp 12345678 1", bus.HRDATA, bus.HREADYOUT);
        end
    endtask

    task automatic test_unmapped();
        bus.PREADY_S1 = 1'b1;
        drive_req(1'b0, 32'h4000_E000, 4'hF, 32'h0);
        tick();
        bus.HSEL = 1'b0;
        checks++;
        if ({bus.PSEL1, bus.PENABLE_S1, bus.HREADYOUT} !== 3'b000) begin
            errors++;
            $display("FAIL miss_busy got %b exp 000", {bus.PSEL1, bus.PENABLE_S1, bus.HREADYOUT});
        end
        tick();
        checks++;
        if ({bus.PSEL1, bus.HREADYOUT} !== 2'b01 || bus.HRDATA !== 32'h0) begin
            errors++;
            $display("FAIL miss_done got psel %b rdy %b hrdata %h exp 0 1 0",
                     bus.PSEL1, bus.HREADYOUT, bus.HRDATA);
        end
    endtask

    task automatic test_back_to_back();
        bus.PREADY_S1 = 1'b0;
        bus.PRDATA_S1 = 32'hCAFE_BABE;
        drive_req(1'b0, 32'h4000_D00C, 4'hF, 32'h0);
        push_exp(1'b0, 32'h4000_D00C, 32'h0, 32'hCAFE_BABE, 4'hF);
        tick();
        drive_req(1'b1, 32'h4000_D010, 4'b0101, 32'h55AA_33CC);
        push_exp(1'b1, 32'h4000_D010, 32'h55AA_33CC, 32'h0, 4'b0101);
        tick();
        checks++;
        if (bus.PADDR_S1 !== 32'h4000_D00C || bus.PENABLE_S1 !== 1'b1) begin
            errors++;
            $display("FAIL busy_ignore got %h en %b exp 4000d00c 1", bus.PADDR_S1, bus.PENABLE_S1);
        end
        bus.PREADY_S1 = 1'b1;
        tick();
        checks++;
        if (bus.HREADYOUT !== 1'b1 || bus.HRDATA !== 32'hCAFE_BABE) begin
            errors++;
            $display("FAIL b2b_first_done got rdy %b hrdata %h exp 1 cafebabe",
                     bus.HREADYOUT, bus.HRDATA);
        end
        tick();
        bus.HSEL = 1'b0;
        checks++;
        if ({bus.PSEL1, bus.PENABLE_S1} !== 2'b10 || bus.PADDR_S1 !== 32'h4000_D010) begin
            errors++;
            $display("FAIL b2b_second_setup got %b %h exp 10 4000d010",
                     {bus.PSEL1, bus.PENABLE_S1}, bus.PADDR_S1);
        end
        tick();
        tick();
        drive_req(1'b1, 32'h4000_E004, 4'hF, 32'h9999_9999);
        tick();
        bus.HSEL = 1'b0;
        tick();
        checks++;
        if (bus.HRDATA !== 32'hCAFE_BABE || bus.PSEL1 !== 1'b0 || bus.HREADYOUT !== 1'b1) begin
            errors++;
            $display("FAIL hrdata_hold got %h psel %b rdy %b exp cafebabe 0 1",
                     bus.HRDATA, bus.PSEL1, bus.HREADYOUT);
        end
    endtask

    task automatic test_reset_mid_access();
        bus.PREADY_S1 = 1'b0;
        drive_req(1'b0, 32'h4000_D014, 4'hF, 32'h0);
        tick();
        bus.HSEL = 1'b0;
        tick();
        checks++;
        if (bus.PENABLE_S1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre got en %b exp 1", bus.PENABLE_S1);
        end
        PRESETn = 1'b1;
        tick();
        checks++;
        if ({bus.PSEL1, bus.PENABLE_S1, bus.HREADYOUT} !== 3'b001 ||
            bus.PADDR_S1 !== 32'h0 || bus.HRDATA !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got %b addr %h hrdata %h exp 001 0 0",
                     {bus.PSEL1, bus.PENABLE_S1, bus.HREADYOUT}, bus.PADDR_S1, bus.HRDATA);
        end
        PRESETn = 1'b0;
        bus.PREADY_S1 = 1'b1;
        tick();
    endtask

    initial begin
        PRESETn = 1'b1;
        bus.HSEL = 1'b0; bus.HREADY = 1'b1; bus.HWRITE = 1'b0;
        bus.HADDR = '0; bus.HBE = '0; bus.HWDATA = '0;
        bus.PREADY_S1 = 1'b1; bus.PRDATA_S1 = '0;
        test_reset();
        test_hready_qual();
        test_write_hit();
        test_read_wait();
        test_unmapped();
        test_back_to_back();
        test_reset_mid_access();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_bus.md
Name: apb_bus

Overview:
- Single-clock bridge from the CPU-side simple bus (HSEL/HADDR/HWRITE/HBE/HWDATA) to an APB master port with one decoded slave (S1).
- Captures one CPU transfer and runs the APB SETUP/ACCESS sequence on the slave.
- Waits for PREADY_S1, returns read data on HRDATA, and signals completion on HREADYOUT.
- Sits between the core's load/store path and the peripheral APB segment.

Parameters:
- ADDR_WIDTH, 32: width of HADDR and PADDR_S1.
- S1_BASE, 32'h4000_D000: base address of the slave-1 window.
- S1_MASK, 32'hFFFF_F000: decode mask. The access hits S1 when (HADDR & S1_MASK) == S1_BASE (a 4 KiB window).

Ports:
- PCLK  in  1  sole clock; everything updates on the rising edge.
- PRESETn  in  1  reset. Synchronous and active-high: PRESETn==1 at a rising edge resets the block.
- HSEL  in  1  transfer request.
- HADDR  in  ADDR_WIDTH  byte address.
- HWRITE  in  1  1=write, 0=read.
- HBE  in  4  byte enables.
- HWDATA  in  32  write data, valid in the same cycle as the address.
- HRDATA  out  32  registered read data.
- HREADY  in  1  upstream qualifier; a request is accepted only when HREADY=1.
- HREADYOUT  out  1  1 = bridge idle or transfer done; 0 = busy.
- PSEL1  out  1  APB select for S1.
- PENABLE_S1  out  1  APB enable.
- PREADY_S1  in  1  slave ready.
- PADDR_S1  out  ADDR_WIDTH  APB address.
- PWRITE_S1  out  1  APB direction.
- PBE_S1  out  4  APB byte strobes.
- PWDATA_S1  out  32  APB write data.
- PRDATA_S1  in  32  slave read data.

Behaviour:
- Reset values: state=IDLE, PSEL1=0, PENABLE_S1=0, PADDR_S1=0, PWRITE_S1=0, PBE_S1=0, PWDATA_S1=0, HRDATA=0, HREADYOUT=1.
- Reset asserted mid-transfer aborts the transfer: the next edge returns the block to IDLE with the reset values.
- States: IDLE, SETUP, ACCESS, NOSLV.
- IDLE:
  - Accept when HSEL && HREADY at a rising edge.
  - On acceptance, register HADDR→PADDR_S1, HWRITE→PWRITE_S1, HBE→PBE_S1, HWDATA→PWDATA_S1.
  - Decode hit → SETUP; decode miss → NOSLV.
  - HREADYOUT=1 in IDLE.
- SETUP (exactly 1 cycle): PSEL1=1, PENABLE_S1=0, HREADYOUT=0. Next state ACCESS.
- ACCESS: PSEL1=1, PENABLE_S1=1, HREADYOUT=0.
  - Wait states: while PREADY_S1=0, remain in ACCESS with all APB outputs held stable.
  - On an edge with PREADY_S1=1: if read, HRDATA<=PRDATA_S1. Drop PSEL1/PENABLE_S1, go to IDLE. HREADYOUT returns to 1 in the following cycle.
- NOSLV (1 cycle):
  - No APB activity; PSEL1 stays 0.
  - A read miss loads HRDATA<=0; a write miss is dropped.
  - HREADYOUT=0 in this cycle; next state IDLE.
- Latency with zero wait states: accept at edge N, SETUP during N..N+1, ACCESS during N+1..N+2. Completion is sampled at edge N+2 and HREADYOUT=1 from N+2.
- PRDATA_S1 is sampled only in ACCESS with PREADY_S1=1.
- HRDATA holds its last read value across writes and idle cycles.
- Requests arriving while busy (HREADYOUT=0) are ignored. The master must hold or retry its request until it sees HREADYOUT=1.
- Back-to-back transfers: a request present in the first IDLE cycle after completion is accepted immediately. There is no bubble beyond IDLE.
- PADDR_S1, PWRITE_S1, PBE_S1 and PWDATA_S1 stay latched after completion until the next acceptance.
- Both reads and writes drive PBE_S1=HBE.

Decomposition:
- Package apb_bus_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, NOSLV);
  - default S1_BASE and S1_MASK constants;
  - the 32-bit data width constant.
- Single module. Address decode is one comparison and needs no sub-module.

Test Plan:
- Reset: PRESETn=1 for 2 edges → all APB outputs 0, HRDATA=0, HREADYOUT=1.
- Write hit: HSEL=1, HREADY=1, HWRITE=1, HADDR=32'h4000_D004, HBE=4'b1111, HWDATA=32'hA5A5_A5A5, PREADY_S1=1 →
  - next cycle: PSEL1=1, PENABLE_S1=0, PADDR_S1=32'h4000_D004, PWDATA_S1=32'hA5A5_A5A5, PWRITE_S1=1, PBE_S1=4'hF;
  - following cycle: PENABLE_S1=1;
  - then PSEL1=0 and HREADYOUT=1.
- Read with 2 wait states: HADDR=32'h4000_D008, HWRITE=0, PRDATA_S1=32'h1234_5678, PREADY_S1 low for 2 ACCESS cycles →
  - ACCESS lasts 3 cycles with outputs stable;
  - HRDATA=32'h1234_5678 after completion.
- Unmapped read: HADDR=32'h4000_E000 → PSEL1 never asserts, HREADYOUT low 1 cycle, HRDATA=0.
- Busy ignore / back-to-back: change HADDR during ACCESS → PADDR_S1 unchanged. A second held request is accepted in the first IDLE cycle.
- Reset mid-ACCESS: assert PRESETn during ACCESS with PREADY_S1=0 → next edge PSEL1=0, PENABLE_S1=0, HREADYOUT=1.
